guess_grader: RTL and testbench
===============================

# guess_grader

Grades a player's 12-bit guess against the loaded 12-bit master pattern. It reports Znarly (right shape, right slot) and Zood (right shape, wrong slot) counts, and tracks rounds and game end. It reads the `masterPattern`/`masterLoaded` pair produced by the master-pattern loader. It sits between the guess-entry logic and the score display.

## Interface
Parameters:
- `MAX_ROUNDS`, default 8: number of graded guesses allowed per game, range 1..15.

Ports:
- `clock`  in  1: system clock; all state changes on the rising edge.
- `reset_N`  in  1: asynchronous, active-low reset.
- `masterPattern`  in  12: four 3-bit shapes. Slot 3 = [11:9], slot 2 = [8:6], slot 1 = [5:3], slot 0 = [2:0].
- `masterLoaded`  in  1: master pattern valid and stable while high.
- `guess`  in  12: guess pattern, same slot layout as `masterPattern`.
- `gradeIt`  in  1: request to grade `guess`; level-sampled.
- `busy`  out  1: high while a grade is in progress (states ZNARLY, COUNT, DONE).
- `znarly`  out  3: last result's Znarly count, 0..4.
- `zood`  out  3: last result's Zood count, 0..4.
- `gradeValid`  out  1: one-cycle pulse; new `znarly`/`zood` are present.
- `roundNumber`  out  4: number of guesses graded in the current game.
- `gameWon`  out  1: sticky; a guess scored `znarly`=4.
- `gameOver`  out  1: sticky; set when `gameWon` is set or `roundNumber` reaches `MAX_ROUNDS`.

## Operation
Shape codes:
- Valid shapes are 3'b001..3'b110.
- Codes 000 and 111 are "empty". An empty code never matches in either the Znarly or the Zood count.

States:
- IDLE: waiting for a request.
  - Accept when `gradeIt`=1, `masterLoaded`=1 and `gameOver`=0.
  - On accept, register `guess` and `masterPattern` into internal copies, clear the accumulators, and go to ZNARLY.
  - A request failing any accept condition is ignored; no state change.
- ZNARLY: one cycle.
  - Znarly = number of slots i where guess[i]==master[i] and the code is valid.
  - Register Znarly, set the shape index to 1, and go to COUNT.
- COUNT: six cycles, shape index s = 1..6.
  - Per cycle, count s in the master copy (mc) and in the guess copy (gc). Each count is 0..4, 3 bits.
  - Add min(mc,gc) into a 3-bit match total.
  - At s=6, go to DONE.
- DONE: one cycle.
  - `znarly` <= Znarly; `zood` <= total − Znarly. Total ≥ Znarly always holds; no underflow.
  - `gradeValid` = 1.
  - `roundNumber` increments, saturating at 15.
  - `gameWon` <= 1 if Znarly==4.
  - `gameOver` <= 1 if Znarly==4 or the new `roundNumber`==`MAX_ROUNDS`.
  - Return to IDLE.

Other rules:
- `gradeIt` is ignored outside IDLE. It is level-sampled, so a `gradeIt` held high re-triggers in the first IDLE cycle after DONE.
- Changes on `guess` or `masterPattern` after the accept edge do not affect the in-progress grade.
- `masterLoaded` falling, in any state: synchronous clear at the next edge.
  - Abort any grade and go to IDLE.
  - `roundNumber`, `gameWon`, `gameOver`, `znarly`, `zood` <= 0.
  - No `gradeValid` pulse for the aborted grade.
- Reset: all outputs and state are 0 (IDLE) immediately on `reset_N` low, independent of `clock`. Reset mid-grade discards the grade.

## Timing
- Accept edge = E0.
- State sequence: ZNARLY after E0, COUNT after E1..E6, DONE after E7, IDLE after E8.
- Outputs:
  - `znarly`, `zood`, `roundNumber`, `gameWon`, `gameOver` update at E8.
  - `gradeValid` is high from E8 to E9 (exactly one cycle).
  - `busy` is high from E0 to E8.
- The earliest next accept is E9 (`gradeIt` sampled high at E8 is ignored; E8 ends DONE). Throughput: one grade per 9 cycles.
- `znarly`/`zood` hold their values until the next DONE or a clear.
- `masterLoaded` low at an edge overrides every other transition at that edge.

## Test plan
- Exact match: master 001_010_011_100, guess identical -> at E8 `znarly`=4, `zood`=0, `gradeValid` pulse 1 cycle, `gameWon`=1, `gameOver`=1, `roundNumber`=1. A further `gradeIt` is ignored.
- Permutation: master 001_010_011_100, guess 100_011_010_001 -> `znarly`=0, `zood`=4, `gameWon`=0.
- Duplicates: master 001_001_010_010, guess 001_010_001_011 -> `znarly`=1, `zood`=2. Then guess 000_000_000_000 -> `znarly`=0, `zood`=0.
- Round limit: `MAX_ROUNDS`=3, three non-winning guesses with `gradeIt` held high -> results at E8, E17, E26. After the third, `roundNumber`=3 and `gameOver`=1. No fourth `gradeValid`.
- Abort: drop `masterLoaded` at E4 of a grade -> IDLE, all outputs 0, no `gradeValid`. Reassert `masterLoaded` and regrade -> normal result at +8 cycles.
- Async reset: assert `reset_N`=0 between edges mid-COUNT -> outputs 0 before the next edge. `gradeIt` with `masterLoaded`=0 -> never accepted.

Source files
------------

// File: rtl/guess_grader.sv
// Grades a 12-bit guess against the loaded master pattern, producing Znarly/Zood
// counts over nine cycles and tracking rounds, win and game-over status.
module guess_grader #(
   parameter int MAX_ROUNDS = 8
) (
   input  logic        clock,
   input  logic        reset_N,
   input  logic [11:0] masterPattern,
   input  logic        masterLoaded,
   input  logic [11:0] guess,
   input  logic        gradeIt,
   output logic        busy,
   output logic [2:0]  znarly,
   output logic [2:0]  zood,
   output logic        gradeValid,
   output logic [3:0]  roundNumber,
   output logic        gameWon,
   output logic        gameOver
);

   typedef enum logic [1:0] {IDLE, ZNARLY, COUNT, DONE} state_t;

   localparam logic [3:0] MaxRounds = 4'(MAX_ROUNDS);

   state_t      state_q, state_d;
   logic [11:0] guessCopy_q, guessCopy_d;
   logic [11:0] masterCopy_q, masterCopy_d;
   logic [2:0]  znarlyAcc_q, znarlyAcc_d;
   logic [2:0]  total_q, total_d;
   logic [2:0]  shape_q, shape_d;
   logic [2:0]  znarly_q, znarly_d;
   logic [2:0]  zood_q, zood_d;
   logic        gradeValid_q, gradeValid_d;
   logic [3:0]  round_q, round_d;
   logic        gameWon_q, gameWon_d;
   logic        gameOver_q, gameOver_d;

   logic [2:0]  masterCount, guessCount;
   logic [3:0]  roundNext;

   function automatic logic [2:0] countShape(input logic [11:0] pat, input logic [2:0] shape);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         if (pat[i*3 +: 3] == shape) n = n + 3'd1;
      end
      return n;
   endfunction

   // Empty codes (000, 111) never count as a positional match.
   function automatic logic [2:0] slotMatches(input logic [11:0] a, input logic [11:0] b);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         if (a[i*3 +: 3] == b[i*3 +: 3] && a[i*3 +: 3] != 3'b000 && a[i*3 +: 3] != 3'b111)
            n = n + 3'd1;
      end
      return n;
   endfunction

   always_comb begin
      state_d      = state_q;
      guessCopy_d  = guessCopy_q;
      masterCopy_d = masterCopy_q;
      znarlyAcc_d  = znarlyAcc_q;
      total_d      = total_q;
      shape_d      = shape_q;
      znarly_d     = znarly_q;
      zood_d       = zood_q;
      gradeValid_d = 1'b0;
      round_d      = round_q;
      gameWon_d    = gameWon_q;
      gameOver_d   = gameOver_q;
      masterCount  = countShape(masterCopy_q, shape_q);
      guessCount   = countShape(guessCopy_q, shape_q);
      roundNext    = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;

      case (state_q)
         IDLE: begin
            if (gradeIt && masterLoaded && !gameOver_q) begin
               guessCopy_d  = guess;
               masterCopy_d = masterPattern;
               znarlyAcc_d  = '0;
               total_d      = '0;
               state_d      = ZNARLY;
            end
         end
         ZNARLY: begin
            znarlyAcc_d = slotMatches(guessCopy_q, masterCopy_q);
            shape_d     = 3'd1;
            state_d     = COUNT;
         end
         COUNT: begin
            total_d = total_q + ((masterCount < guessCount) ? masterCount : guessCount);
            if (shape_q == 3'd6) state_d = DONE;
            else                 shape_d = shape_q + 3'd1;
         end
         DONE: begin
            znarly_d     = znarlyAcc_q;
            zood_d       = total_q - znarlyAcc_q;
            gradeValid_d = 1'b1;
            round_d      = roundNext;
            if (znarlyAcc_q == 3'd4) gameWon_d = 1'b1;
            if (znarlyAcc_q == 3'd4 || roundNext == MaxRounds) gameOver_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Losing the master pattern abandons the game outright.
      if (!masterLoaded) begin
         state_d      = IDLE;
         gradeValid_d = 1'b0;
         round_d      = '0;
         gameWon_d    = 1'b0;
         gameOver_d   = 1'b0;
         znarly_d     = '0;
         zood_d       = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_q      <= IDLE;
         guessCopy_q  <= '0;
         masterCopy_q <= '0;
         znarlyAcc_q  <= '0;
         total_q      <= '0;
         shape_q      <= '0;
         znarly_q     <= '0;
         zood_q       <= '0;
         gradeValid_q <= 1'b0;
         round_q      <= '0;
         gameWon_q    <= 1'b0;
         gameOver_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         guessCopy_q  <= guessCopy_d;
         masterCopy_q <= masterCopy_d;
         znarlyAcc_q  <= znarlyAcc_d;
         total_q      <= total_d;
         shape_q      <= shape_d;
         znarly_q     <= znarly_d;
         zood_q       <= zood_d;
         gradeValid_q <= gradeValid_d;
         round_q      <= round_d;
         gameWon_q    <= gameWon_d;
         gameOver_q   <= gameOver_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign znarly      = znarly_q;
   assign zood        = zood_q;
   assign gradeValid  = gradeValid_q;
   assign roundNumber = round_q;
   assign gameWon     = gameWon_q;
   assign gameOver    = gameOver_q;

endmodule

// File: tb/tb_guess_grader.sv
// Testbench for guess_grader: directed scenarios plus random games compared
// against a whole-guess scoring model of the game.
module tb_guess_grader;

   localparam int TbMaxRounds = 3;

   logic        clock;
   logic        reset_N;
   logic [11:0] masterPattern;
   logic        masterLoaded;
   logic [11:0] guess;
   logic        gradeIt;
   logic        busy;
   logic [2:0]  znarly;
   logic [2:0]  zood;
   logic        gradeValid;
   logic [3:0]  roundNumber;
   logic        gameWon;
   logic        gameOver;

   int checkCount = 0;
   int errorCount = 0;

   int mZnarly = 0;
   int mZood   = 0;
   int mRound  = 0;
   bit mWon    = 0;
   bit mOver   = 0;

   guess_grader #(.MAX_ROUNDS(TbMaxRounds)) dut (
      .clock         (clock),
      .reset_N       (reset_N),
      .masterPattern (masterPattern),
      .masterLoaded  (masterLoaded),
      .guess         (guess),
      .gradeIt       (gradeIt),
      .busy          (busy),
      .znarly        (znarly),
      .zood          (zood),
      .gradeValid    (gradeValid),
      .roundNumber   (roundNumber),
      .gameWon       (gameWon),
      .gameOver      (gameOver)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Score a whole guess at once: positional matches plus shape-multiset overlap.
   function automatic void modelGrade(input logic [11:0] m, input logic [11:0] g,
                                      output int zn, output int zo);
      int mCnt[8];
      int gCnt[8];
      int common;
      int ms;
      int gs;
      for (int k = 0; k < 8; k++) begin
         mCnt[k] = 0;
         gCnt[k] = 0;
      end
      zn = 0;
      common = 0;
      for (int slot = 0; slot < 4; slot++) begin
         ms = int'(m[slot*3 +: 3]);
         gs = int'(g[slot*3 +: 3]);
         if (ms == gs && ms >= 1 && ms <= 6) zn++;
         mCnt[ms]++;
         gCnt[gs]++;
      end
      for (int sh = 1; sh <= 6; sh++) common += (mCnt[sh] < gCnt[sh]) ? mCnt[sh] : gCnt[sh];
      zo = common - zn;
   endfunction

   task automatic modelClear();
      mZnarly = 0;
      mZood   = 0;
      mRound  = 0;
      mWon    = 0;
      mOver   = 0;
   endtask

   task automatic checkResults(input string tag);
      checkOutput({tag, ".znarly"}, znarly, mZnarly);
      checkOutput({tag, ".zood"}, zood, mZood);
      checkOutput({tag, ".round"}, roundNumber, mRound);
      checkOutput({tag, ".won"}, gameWon, mWon);
      checkOutput({tag, ".over"}, gameOver, mOver);
   endtask

   // One request, entered at #1 after an edge; returns at #1 after the last checked edge.
   task automatic applyStimulus(input string tag, input logic [11:0] m, input logic [11:0] g);
      int expZn;
      int expZo;
      bit accept;
      masterPattern = m;
      guess         = g;
      gradeIt       = 1'b1;
      accept        = masterLoaded && !mOver;
      modelGrade(m, g, expZn, expZo);
      @(posedge clock); #1;
      gradeIt       = 1'b0;
      masterPattern = ~m;
      guess         = ~g;
      checkOutput({tag, ".busyE0"}, busy, int'(accept));
      if (accept) begin
         for (int k = 1; k <= 7; k++) begin
            @(posedge clock); #1;
            checkOutput({tag, ".busy"}, busy, 1);
            checkOutput({tag, ".earlyValid"}, gradeValid, 0);
         end
         @(posedge clock); #1;
         mZnarly = expZn;
         mZood   = expZo;
         mRound  = (mRound == 15) ? 15 : mRound + 1;
         if (expZn == 4) mWon = 1;
         if (expZn == 4 || mRound == TbMaxRounds) mOver = 1;
         checkOutput({tag, ".validE8"}, gradeValid, 1);
         checkOutput({tag, ".busyE8"}, busy, 0);
         checkResults(tag);
         @(posedge clock); #1;
         checkOutput({tag, ".validE9"}, gradeValid, 0);
      end else begin
         for (int k = 1; k <= 9; k++) begin
            @(posedge clock); #1;
            checkOutput({tag, ".idleBusy"}, busy, 0);
            checkOutput({tag, ".idleValid"}, gradeValid, 0);
         end
         checkResults(tag);
      end
   endtask

   task automatic clearGame(input string tag);
      masterLoaded = 1'b0;
      @(posedge clock); #1;
      modelClear();
      checkOutput({tag, ".busy"}, busy, 0);
      checkResults(tag);
      masterLoaded = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      logic [11:0] rm;
      logic [11:0] rg;
      int pulses;
      reset_N       = 1'b0;
      masterLoaded  = 1'b0;
      masterPattern = '0;
      guess         = '0;
      gradeIt       = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.valid", gradeValid, 0);
      checkResults("reset");
      reset_N      = 1'b1;
      masterLoaded = 1'b1;
      @(posedge clock); #1;

      applyStimulus("exact", 12'b001_010_011_100, 12'b001_010_011_100);
      applyStimulus("afterWin", 12'b001_010_011_100, 12'b100_011_010_001);
      clearGame("clear1");

      applyStimulus("perm", 12'b001_010_011_100, 12'b100_011_010_001);
      applyStimulus("dup", 12'b001_001_010_010, 12'b001_010_001_011);
      applyStimulus("empty", 12'b001_001_010_010, 12'b000_000_000_000);
      applyStimulus("overIgnored", 12'b001_001_010_010, 12'b001_001_010_010);
      clearGame("clear2");

      // gradeIt held high across a full game.
      masterPattern = 12'b001_010_011_100;
      guess         = 12'b100_011_010_001;
      gradeIt       = 1'b1;
      pulses        = 0;
      for (int cyc = 0; cyc <= 40; cyc++) begin
         @(posedge clock); #1;
         if (gradeValid) begin
            checkOutput("held.pulseEdge", cyc, 8 + 9 * pulses);
            pulses++;
         end
      end
      gradeIt = 1'b0;
      mZnarly = 0; mZood = 4; mRound = 3; mWon = 0; mOver = 1;
      checkOutput("held.pulseCount", pulses, 3);
      checkResults("held");
      clearGame("clear3");

      applyStimulus("preAbort", 12'b011_011_101_110, 12'b011_101_011_001);
      masterPattern = 12'b001_010_011_100;
      guess         = 12'b001_010_011_100;
      gradeIt       = 1'b1;
      @(posedge clock); #1;
      gradeIt = 1'b0;
      checkOutput("abort.busyE0", busy, 1);
      repeat (3) @(posedge clock);
      #1;
      masterLoaded = 1'b0;
      @(posedge clock); #1;
      modelClear();
      checkOutput("abort.busy", busy, 0);
      checkResults("abort");
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         checkOutput("abort.noValid", gradeValid, 0);
      end
      masterLoaded = 1'b1;
      @(posedge clock); #1;
      applyStimulus("regrade", 12'b110_101_100_011, 12'b110_100_101_010);

      for (int n = 0; n < 40; n++) begin
         if (mOver) clearGame("randClear");
         for (int s = 0; s < 4; s++) rm[s*3 +: 3] = 3'($urandom_range(0, 7));
         for (int s = 0; s < 4; s++) begin
            case ($urandom_range(0, 3))
               0:       rg[s*3 +: 3] = rm[s*3 +: 3];
               1:       rg[s*3 +: 3] = rm[((s + 1) % 4)*3 +: 3];
               default: rg[s*3 +: 3] = 3'($urandom_range(0, 7));
            endcase
         end
         if ($urandom_range(0, 5) == 0) rg = rm;
         applyStimulus("rand", rm, rg);
      end

      clearGame("clear4");
      applyStimulus("preReset", 12'b010_010_011_011, 12'b011_010_010_001);
      masterPattern = 12'b001_010_011_100;
      guess         = 12'b001_010_011_100;
      gradeIt       = 1'b1;
      @(posedge clock); #1;
      gradeIt = 1'b0;
      repeat (3) @(posedge clock);
      #3;
      reset_N = 1'b0;
      #1;
      modelClear();
      checkOutput("async.busy", busy, 0);
      checkOutput("async.valid", gradeValid, 0);
      checkResults("async");
      @(posedge clock); #1;
      reset_N      = 1'b1;
      masterLoaded = 1'b0;
      gradeIt      = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clock); #1;
         checkOutput("noMaster.busy", busy, 0);
         checkOutput("noMaster.valid", gradeValid, 0);
      end
      gradeIt = 1'b0;
      checkResults("noMaster");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
